vga_sync_generator: RTL and testbench

- Produces VGA raster timing: horizontal/vertical pixel counters, HSYNC/VSYNC, display enable, and per-line and per-frame strobes.
- Drives the `h_count`/`v_count` bus that the colour-generation stage consumes.
- Drives the sync pins of the VGA connector directly.
- `frame_tick` marks the start of vertical blanking, so player/car position logic updates off-screen.

---
 rtl/vga_sync_generator.sv | 117 +++++++++++
 tb/tb_vga_sync_generator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: VGA raster timing generator.
// Produces pixel/line counters, registered sync pulses and display enable that
// line up with the counter values presented in the same cycle, plus one-cycle
// line/frame strobes and a wrapping frame counter.
module vga_sync_generator #(
    parameter int H_DISPLAY       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_DISPLAY       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int PIXEL_DIV       = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       VGA_HSYNC,
    output logic       VGA_VSYNC,
    output logic       display_en,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_FRAME  = 10'(V_DISPLAY);

    // Window bounds are 11 bits so a sync pulse ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    localparam logic [1:0]  DIV_LAST  = 2'(PIXEL_DIV - 1);
    localparam logic        SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [1:0] div_cnt;
    logic       pix_ce;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hs_next;
    logic       vs_next;
    logic       de_next;
    logic       lt_next;
    logic       ft_next;

    // Pixel enable fires on the last clock of each pixel period
    always_comb begin
        pix_ce = (div_cnt == DIV_LAST);
    end

    // Next counter position and the timing outputs that belong to it
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (pix_ce) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
            end else begin
                h_next = h_count + 10'd1;
            end
        end
        hs_next = SYNC_IDLE ^ (({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END));
        vs_next = SYNC_IDLE ^ (({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END));
        de_next = ({1'b0, h_next} < H_VIS) && ({1'b0, v_next} < V_VIS);
        lt_next = pix_ce && (h_next == 10'd0);
        ft_next = lt_next && (v_next == V_FRAME);
    end

    // Pixel-clock divider
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
        end else if (pix_ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 2'd1;
        end
    end

    // Counters and registered timing outputs, all aligned to the same position
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_count     <= H_LAST;
            v_count     <= V_LAST;
            VGA_HSYNC   <= SYNC_IDLE;
            VGA_VSYNC   <= SYNC_IDLE;
            display_en  <= 1'b0;
            line_tick   <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            h_count    <= h_next;
            v_count    <= v_next;
            VGA_HSYNC  <= hs_next;
            VGA_VSYNC  <= vs_next;
            display_en <= de_next;
            line_tick  <= lt_next;
            frame_tick <= ft_next;
            if (ft_next) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: self-checking bench for vga_sync_generator.
// Four instances with different timing parameters share clock and reset; every
// cycle each one is compared against a closed-form raster model, plus a table of
// hand-derived points on the default 640x480 instance and tick-period checks.
module tb_vga_sync_generator;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       lt;
        logic       ft;
        logic [7:0] fc;
    } out_t;

    typedef struct {
        longint     k;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       lt;
        logic       ft;
    } vec_t;

    logic       CLK;
    logic       RST_N;
    logic [9:0] h_c [4];
    logic [9:0] v_c [4];
    logic       hs_c [4];
    logic       vs_c [4];
    logic       de_c [4];
    logic       lt_c [4];
    logic       ft_c [4];
    logic [7:0] fc_c [4];

    int     tests_run = 0;
    int     tests_failed = 0;
    longint k = 0;
    longint last_lt_div2 = 0;
    longint last_ft_mid = 0;
    bit     saw_wrap = 0;
    vec_t   vecs [10];
    int     vec_idx = 0;
    bit     use_table = 0;

    vga_sync_generator u_def (
        .CLK(CLK), .RST_N(RST_N), .h_count(h_c[0]), .v_count(v_c[0]),
        .VGA_HSYNC(hs_c[0]), .VGA_VSYNC(vs_c[0]), .display_en(de_c[0]),
        .line_tick(lt_c[0]), .frame_tick(ft_c[0]), .frame_count(fc_c[0])
    );

    vga_sync_generator #(.PIXEL_DIV(2)) u_div2 (
        .CLK(CLK), .RST_N(RST_N), .h_count(h_c[1]), .v_count(v_c[1]),
        .VGA_HSYNC(hs_c[1]), .VGA_VSYNC(vs_c[1]), .display_en(de_c[1]),
        .line_tick(lt_c[1]), .frame_tick(ft_c[1]), .frame_count(fc_c[1])
    );

    vga_sync_generator #(
        .H_DISPLAY(1), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE_LOW(1), .PIXEL_DIV(1)
    ) u_fast (
        .CLK(CLK), .RST_N(RST_N), .h_count(h_c[2]), .v_count(v_c[2]),
        .VGA_HSYNC(hs_c[2]), .VGA_VSYNC(vs_c[2]), .display_en(de_c[2]),
        .line_tick(lt_c[2]), .frame_tick(ft_c[2]), .frame_count(fc_c[2])
    );

    vga_sync_generator #(
        .H_DISPLAY(20), .H_FRONT(2), .H_SYNC(4), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE_LOW(0), .PIXEL_DIV(3)
    ) u_mid (
        .CLK(CLK), .RST_N(RST_N), .h_count(h_c[3]), .v_count(v_c[3]),
        .VGA_HSYNC(hs_c[3]), .VGA_VSYNC(vs_c[3]), .display_en(de_c[3]),
        .line_tick(lt_c[3]), .frame_tick(ft_c[3]), .frame_count(fc_c[3])
    );

    // 10 ns clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Raster position after k clock edges since reset release: pixel n = k/div,
    // scan position is n-1 along the frame (n=0 is the reset corner).
    function automatic out_t model(longint kk, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb, int sal, int div);
        out_t   o;
        longint ht = hd + hf + hsw + hb;
        longint vt = vd + vf + vsw + vb;
        longint f  = ht * vt;
        longint n  = kk / div;
        longint lin = (n + f - 1) % f;
        longint h  = lin % ht;
        longint v  = lin / ht;
        longint frames;
        bit     ce = (kk > 0) && (kk % div == 0);
        bit     hs_act = (h >= hd + hf) && (h < hd + hf + hsw);
        bit     vs_act = (v >= vd + vf) && (v < vd + vf + vsw);
        o.h  = 10'(h);
        o.v  = 10'(v);
        o.hs = (sal != 0) ? !hs_act : hs_act;
        o.vs = (sal != 0) ? !vs_act : vs_act;
        o.de = (h < hd) && (v < vd);
        o.lt = ce && (h == 0);
        o.ft = ce && (h == 0) && (v == vd);
        if (n >= 1 && (n - 1) >= longint'(vd) * ht) frames = (n - 1 - longint'(vd) * ht) / f + 1;
        else frames = 0;
        o.fc = 8'(frames % 256);
        return o;
    endfunction

    function automatic out_t expect_for(int i, longint kk);
        case (i)
            0:       return model(kk, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1);
            1:       return model(kk, 640, 16, 96, 48, 480, 10, 2, 33, 1, 2);
            2:       return model(kk, 1, 2, 3, 2, 1, 1, 1, 1, 1, 1);
            default: return model(kk, 20, 2, 4, 4, 12, 2, 2, 3, 0, 3);
        endcase
    endfunction

    function automatic out_t gather(int i);
        out_t o;
        o.h  = h_c[i];
        o.v  = v_c[i];
        o.hs = hs_c[i];
        o.vs = vs_c[i];
        o.de = de_c[i];
        o.lt = lt_c[i];
        o.ft = ft_c[i];
        o.fc = fc_c[i];
        return o;
    endfunction

    // Compare one instance against the model at the current edge count
    task automatic checkOutput(int i, string tag);
        out_t e = expect_for(i, k);
        out_t a = gather(i);
        tests_run++;
        if (a !== e) begin
            tests_failed++;
            $display("[TB] FAIL %s inst%0d k=%0d: got h=%0d v=%0d hs=%b vs=%b de=%b lt=%b ft=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b de=%b lt=%b ft=%b fc=%0d",
                     tag, i, k, a.h, a.v, a.hs, a.vs, a.de, a.lt, a.ft, a.fc,
                     e.h, e.v, e.hs, e.vs, e.de, e.lt, e.ft, e.fc);
        end
    endtask

    // Compare the default instance against a hand-derived table entry
    task automatic checkVector(vec_t t);
        tests_run++;
        if (h_c[0] !== t.h || v_c[0] !== t.v || hs_c[0] !== t.hs || vs_c[0] !== t.vs ||
            de_c[0] !== t.de || lt_c[0] !== t.lt || ft_c[0] !== t.ft) begin
            tests_failed++;
            $display("[TB] FAIL table k=%0d: got h=%0d v=%0d hs=%b vs=%b de=%b lt=%b ft=%b, expected h=%0d v=%0d hs=%b vs=%b de=%b lt=%b ft=%b",
                     t.k, h_c[0], v_c[0], hs_c[0], vs_c[0], de_c[0], lt_c[0], ft_c[0],
                     t.h, t.v, t.hs, t.vs, t.de, t.lt, t.ft);
        end
    endtask

    task automatic checkPeriod(string tag, longint got, longint want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got period %0d, expected %0d", tag, got, want);
        end
    endtask

    // Run free for a number of cycles, checking every instance after each edge
    task automatic applyStimulus(int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge CLK);
            #1;
            k++;
            for (int i = 0; i < 4; i++) checkOutput(i, "raster");
            if (use_table && vec_idx < 10 && vecs[vec_idx].k == k) begin
                checkVector(vecs[vec_idx]);
                vec_idx++;
            end
            if (lt_c[1] === 1'b1) begin
                if (last_lt_div2 > 0) checkPeriod("div2_line_period", k - last_lt_div2, 1600);
                last_lt_div2 = k;
            end
            if (ft_c[3] === 1'b1) begin
                if (last_ft_mid > 0) checkPeriod("mid_frame_period", k - last_ft_mid, 1710);
                last_ft_mid = k;
            end
            if (ft_c[2] === 1'b1 && fc_c[2] === 8'd0) saw_wrap = 1;
        end
    endtask

    // Assert reset at a random point inside a low clock phase; outputs must take
    // reset values before the next rising edge and hold through it
    task automatic applyReset();
        @(negedge CLK);
        #($urandom_range(1, 3));
        RST_N = 1'b0;
        #1;
        k = 0;
        last_lt_div2 = 0;
        last_ft_mid = 0;
        for (int i = 0; i < 4; i++) checkOutput(i, "async_reset");
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) checkOutput(i, "reset_hold");
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        vecs[0] = '{k:1,    h:0,   v:0, hs:1, vs:1, de:1, lt:1, ft:0};
        vecs[1] = '{k:640,  h:639, v:0, hs:1, vs:1, de:1, lt:0, ft:0};
        vecs[2] = '{k:641,  h:640, v:0, hs:1, vs:1, de:0, lt:0, ft:0};
        vecs[3] = '{k:656,  h:655, v:0, hs:1, vs:1, de:0, lt:0, ft:0};
        vecs[4] = '{k:657,  h:656, v:0, hs:0, vs:1, de:0, lt:0, ft:0};
        vecs[5] = '{k:752,  h:751, v:0, hs:0, vs:1, de:0, lt:0, ft:0};
        vecs[6] = '{k:753,  h:752, v:0, hs:1, vs:1, de:0, lt:0, ft:0};
        vecs[7] = '{k:800,  h:799, v:0, hs:1, vs:1, de:0, lt:0, ft:0};
        vecs[8] = '{k:801,  h:0,   v:1, hs:1, vs:1, de:1, lt:1, ft:0};
        vecs[9] = '{k:1601, h:0,   v:2, hs:1, vs:1, de:1, lt:1, ft:0};

        RST_N = 1'b0;
        #23;
        for (int i = 0; i < 4; i++) checkOutput(i, "power_on_reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // First line(s) of the default raster, first mid-sized frames
        use_table = 1;
        applyStimulus(3000);
        use_table = 0;
        tests_run++;
        if (vec_idx != 10) begin
            tests_failed++;
            $display("[TB] FAIL table_coverage: got %0d entries checked, expected 10", vec_idx);
        end

        // Long run so the tiny raster wraps its frame counter
        applyReset();
        saw_wrap = 0;
        applyStimulus(8400);
        tests_run++;
        if (!saw_wrap) begin
            tests_failed++;
            $display("[TB] FAIL fast_frame_wrap: got no 255->0 wrap, expected one");
        end

        // Random mid-frame resets followed by random run lengths
        for (int s = 0; s < 4; s++) begin
            applyReset();
            applyStimulus(int'($urandom_range(200, 3000)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
